// File: rtl/synth_core_sysid_pkg.sv
// System-ID register bank: shared word offsets, CTRL bit positions
// and the CAPS word packing.
package synth_core_sysid_pkg;

  localparam logic [31:0] ADDR_ID      = 32'd0;
  localparam logic [31:0] ADDR_TS      = 32'd1;
  localparam logic [31:0] ADDR_CAPS    = 32'd2;
  localparam logic [31:0] ADDR_SCRATCH = 32'd3;
  localparam logic [31:0] ADDR_UPLO    = 32'd4;
  localparam logic [31:0] ADDR_UPHI    = 32'd5;
  localparam logic [31:0] ADDR_CTRL    = 32'd6;
  localparam logic [31:0] ADDR_RSVD    = 32'd7;
  localparam logic [31:0] ADDR_INFO0   = 32'd8;

  localparam int CTRL_CLR    = 0;
  localparam int CTRL_FREEZE = 1;

  function automatic logic [31:0] caps_word(
    input int          num_info,
    input int          addr_w,
    input logic [15:0] version
  );
    logic [31:0] n;
    logic [31:0] a;
    n = 32'(num_info);
    a = 32'(addr_w);
    return {n[7:0], a[7:0], version};
  endfunction

endpackage

// File: rtl/synth_core_uptime_counter.sv
// Free-running 64-bit uptime counter with clear, freeze and a
// high-word shadow captured whenever the low word is read.
module synth_core_uptime_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        freeze,
  input  logic        snap,
  output logic [63:0] count,
  output logic [31:0] hi_shadow
);

  logic [63:0] cnt_q;

  // Snapshot uses the pre-update count, so a LO read that coincides
  // with a clear still pairs with the matching pre-clear high word.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_shadow <= '0;
    end else begin
      if (snap) begin
        hi_shadow <= cnt_q[63:32];
      end
      if (clr) begin
        cnt_q <= '0;
      end else if (!freeze) begin
        cnt_q <= cnt_q + 64'd1;
      end
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/synth_core_sysid_regs.sv
// Avalon-MM system-ID register bank: identity, caps, scratch,
// uptime with atomic LO/HI snapshot and constant info words.
module synth_core_sysid_regs
  import synth_core_sysid_pkg::*;
#(
  parameter int          ADDR_W      = 4,
  parameter logic [31:0] SYSTEM_ID   = 32'h5290_0001,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter logic [15:0] VERSION     = 16'h0200,
  parameter int          NUM_INFO    = 4,
  parameter logic [32*(NUM_INFO > 0 ? NUM_INFO : 1)-1:0]
                         INFO_INIT   = '0,
  parameter logic [31:0] SCRATCH_RST = 32'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  if (8 + NUM_INFO > (2 ** ADDR_W)) begin : g_map_too_big
    $error("sysid map does not fit in 2**ADDR_W words");
  end

  localparam logic [31:0] CAPS =
    caps_word(NUM_INFO, ADDR_W, VERSION);

  logic [31:0] addr_w;
  logic [31:0] scratch;
  logic        freeze;
  logic        wr_scratch;
  logic        wr_ctrl;
  logic        clr;
  logic        snap;
  logic [63:0] count;
  logic [31:0] hi_shadow;
  logic [31:0] rd_word;
  logic        unused_cnt_hi;

  assign addr_w = 32'(address);

  assign wr_scratch = write && (addr_w == ADDR_SCRATCH);
  assign wr_ctrl    = write && (addr_w == ADDR_CTRL);
  assign clr        = wr_ctrl && byteenable[0]
                      && writedata[CTRL_CLR];
  assign snap       = read && (addr_w == ADDR_UPLO);

  synth_core_uptime_counter u_cnt (
    .clock     (clock),
    .reset     (reset),
    .clr       (clr),
    .freeze    (freeze),
    .snap      (snap),
    .count     (count),
    .hi_shadow (hi_shadow)
  );

  // The live high word is only observable through the shadow.
  assign unused_cnt_hi = ^count[63:32];

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch <= SCRATCH_RST;
      freeze  <= 1'b0;
    end else begin
      if (wr_scratch) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) begin
            scratch[8*b +: 8] <= writedata[8*b +: 8];
          end
        end
      end
      if (wr_ctrl && byteenable[0]) begin
        freeze <= writedata[CTRL_FREEZE];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (addr_w)
      ADDR_ID:      rd_word = SYSTEM_ID;
      ADDR_TS:      rd_word = TIMESTAMP;
      ADDR_CAPS:    rd_word = CAPS;
      ADDR_SCRATCH: rd_word = scratch;
      ADDR_UPLO:    rd_word = count[31:0];
      ADDR_UPHI:    rd_word = hi_shadow;
      ADDR_CTRL:    rd_word = {30'd0, freeze, 1'b0};
      ADDR_RSVD:    rd_word = '0;
      default:      rd_word = '0;
    endcase
    for (int i = 0; i < NUM_INFO; i++) begin
      if (addr_w == ADDR_INFO0 + 32'(i)) begin
        rd_word = INFO_INIT[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= rd_word;
      end
    end
  end

endmodule
